// File: rtl/alu_pkg.sv
// Shared definitions for the wide sequential ALU: limb width, ALUop encodings and FSM states.
package alu_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] ALUOP_AND = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_ADD = 3'b010;
    localparam logic [2:0] ALUOP_SUB = 3'b110;
    localparam logic [2:0] ALUOP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // SLT is evaluated as a subtract, so it shares the inverted-B / carry-in-1 path with SUB.
    function automatic logic is_sub_op(input logic [2:0] op);
        return (op == ALUOP_SUB) || (op == ALUOP_SLT);
    endfunction

endpackage

// File: rtl/alu_wide_seq_if.sv
// Request/response bundle between the datapath sequencer (master) and the wide ALU (slave).
interface alu_wide_seq_if #(
    parameter int W = 128
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   ALUop;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Result;
    logic         Overflow;
    logic         CarryOut;
    logic         Zero;

    modport master (
        output in_valid, ALUop, A, B, out_ready,
        input  in_ready, out_valid, Result, Overflow, CarryOut, Zero
    );

    modport slave (
        input  in_valid, ALUop, A, B, out_ready,
        output in_ready, out_valid, Result, Overflow, CarryOut, Zero
    );
endinterface

// File: rtl/alu_wide_seq_limb_addsub.sv
// One-limb adder/subtractor; also exposes the carry into the limb MSB for overflow detection.
module limb_addsub
    import alu_pkg::*;
#(
    parameter int DW = alu_pkg::DATA_WIDTH
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          cin,
    input  logic          is_sub,
    output logic [DW-1:0] sum,
    output logic          cout,
    output logic          cin_msb
);

    logic [DW-1:0] b_eff;
    logic [DW:0]   full;
    logic [DW-1:0] low;

    // The low DW-1 bits are added separately so their carry-out is the carry into the MSB.
    always_comb begin
        b_eff   = is_sub ? ~b : b;
        full    = {1'b0, a} + {1'b0, b_eff} + {{DW{1'b0}}, cin};
        low     = {1'b0, a[DW-2:0]} + {1'b0, b_eff[DW-2:0]} + {{(DW-1){1'b0}}, cin};
        sum     = full[DW-1:0];
        cout    = full[DW];
        cin_msb = low[DW-1];
    end

endmodule

// File: rtl/alu_wide_seq.sv
// Multi-precision ALU: processes one limb per cycle LSB first, chaining carry between limbs,
// and presents Result/flags through a valid/ready handshake.
module alu_wide_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int LIMBS      = 4
) (
    input  logic          clk,
    input  logic          resetn,
    alu_wide_seq_if.slave bus
);

    localparam int W     = DATA_WIDTH * LIMBS;
    localparam int ACC_W = W - DATA_WIDTH;
    localparam int IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    state_t                  state;
    state_t                  state_next;
    logic [W-1:0]            a_sh;
    logic [W-1:0]            b_sh;
    logic [ACC_W-1:0]        acc;
    logic [2:0]              op_q;
    logic                    sub_q;
    logic                    carry_q;
    logic                    zacc_q;
    logic [IDX_W-1:0]        idx_q;
    logic [W-1:0]            result_q;
    logic                    ovf_q;
    logic                    cy_q;
    logic                    zero_q;

    logic [DATA_WIDTH-1:0]   sum;
    logic                    cout;
    logic                    cin_msb;
    logic [DATA_WIDTH-1:0]   limb;
    logic                    last;
    logic                    zacc_next;
    logic                    ovf;
    logic                    slt_bit;
    logic [W-1:0]            final_result;
    logic                    final_ovf;
    logic                    final_cy;
    logic                    final_zero;

    limb_addsub #(.DW(DATA_WIDTH)) u_addsub (
        .a       (a_sh[DATA_WIDTH-1:0]),
        .b       (b_sh[DATA_WIDTH-1:0]),
        .cin     (carry_q),
        .is_sub  (sub_q),
        .sum     (sum),
        .cout    (cout),
        .cin_msb (cin_msb)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = RUN;
            RUN:     if (last)         state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.Result    = result_q;
        bus.Overflow  = ovf_q;
        bus.CarryOut  = cy_q;
        bus.Zero      = zero_q;
    end

    // Current limb value and the full-word result/flags as they would stand after the top limb.
    always_comb begin
        last = (idx_q == IDX_W'(LIMBS - 1));
        case (op_q)
            ALUOP_AND:                       limb = a_sh[DATA_WIDTH-1:0] & b_sh[DATA_WIDTH-1:0];
            ALUOP_OR:                        limb = a_sh[DATA_WIDTH-1:0] | b_sh[DATA_WIDTH-1:0];
            ALUOP_ADD, ALUOP_SUB, ALUOP_SLT: limb = sum;
            default:                         limb = '0;
        endcase
        zacc_next    = zacc_q | (|limb);
        ovf          = cin_msb ^ cout;
        slt_bit      = sum[DATA_WIDTH-1] ^ ovf;
        final_result = {limb, acc};
        final_ovf    = 1'b0;
        final_cy     = 1'b0;
        final_zero   = ~zacc_next;
        case (op_q)
            ALUOP_AND, ALUOP_OR: ;
            ALUOP_ADD, ALUOP_SUB: begin
                final_ovf = ovf;
                final_cy  = cout ^ sub_q;
            end
            ALUOP_SLT: begin
                final_result = {{(W-1){1'b0}}, slt_bit};
                final_ovf    = ovf;
                final_cy     = cout ^ sub_q;
                final_zero   = ~slt_bit;
            end
            default: begin
                final_result = '0;
                final_zero   = 1'b1;
            end
        endcase
    end

    // Operands shift right a limb per cycle; finished limbs enter acc from the top so the
    // lowest limb lands at the bottom once LIMBS-1 limbs have been collected.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            op_q     <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            cy_q     <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh    <= bus.A;
                        b_sh    <= bus.B;
                        op_q    <= bus.ALUop;
                        sub_q   <= is_sub_op(bus.ALUop);
                        carry_q <= is_sub_op(bus.ALUop);
                        zacc_q  <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= {{DATA_WIDTH{1'b0}}, a_sh[W-1:DATA_WIDTH]};
                    b_sh    <= {{DATA_WIDTH{1'b0}}, b_sh[W-1:DATA_WIDTH]};
                    carry_q <= cout;
                    zacc_q  <= zacc_next;
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        result_q <= final_result;
                        ovf_q    <= final_ovf;
                        cy_q     <= final_cy;
                        zero_q   <= final_zero;
                    end else begin
                        acc <= {limb, acc[ACC_W-1:DATA_WIDTH]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Self-checking bench for alu_wide_seq: directed corner cases, backpressure, mid-op reset and
// random ops compared against a whole-word arithmetic reference model.
module tb_alu_wide_seq;
    import alu_pkg::*;

    localparam int DW    = 32;
    localparam int LIMBS = 4;
    localparam int W     = DW * LIMBS;

    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_wide_seq_if #(.W(W)) bus ();

    alu_wide_seq #(.DATA_WIDTH(DW), .LIMBS(LIMBS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void refModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] r, output logic v, output logic c, output logic z);
        logic [W:0] s;
        r = '0;
        v = 1'b0;
        c = 1'b0;
        case (op)
            ALUOP_AND: r = a & b;
            ALUOP_OR:  r = a | b;
            ALUOP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            ALUOP_SUB, ALUOP_SLT: begin
                r = a - b;
                c = (a < b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
                if (op == ALUOP_SLT) r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            end
            default: r = '0;
        endcase
        z = (r == '0);
    endfunction

    function automatic logic [W-1:0] randWord();
        logic [W-1:0] w;
        case ($urandom_range(0, 7))
            0:       w = '0;
            1:       w = '1;
            2:       w = {1'b1, {(W-1){1'b0}}};
            3:       w = {1'b0, {(W-1){1'b1}}};
            default: w = {$urandom, $urandom, $urandom, $urandom};
        endcase
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit seen;
        int lat;
        @(negedge clk);
        bus.ALUop    = op;
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({tag, "/accept"}, W'(seen), W'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput({tag, "/busy"}, W'(bus.in_ready), W'(0));
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "/latency"}, W'(lat), W'(LIMBS));
    endtask

    task automatic checkResult(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic v, c, z;
        refModel(op, a, b, r, v, c, z);
        @(negedge clk);
        checkOutput({tag, "/out_valid"}, W'(bus.out_valid), W'(1));
        checkOutput({tag, "/Result"},    bus.Result,        r);
        checkOutput({tag, "/Overflow"},  W'(bus.Overflow),  W'(v));
        checkOutput({tag, "/CarryOut"},  W'(bus.CarryOut),  W'(c));
        checkOutput({tag, "/Zero"},      W'(bus.Zero),      W'(z));
    endtask

    task automatic popResult(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, "/pop_valid"}, W'(bus.out_valid), W'(0));
        checkOutput({tag, "/pop_ready"}, W'(bus.in_ready),  W'(1));
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        applyStimulus(tag, op, a, b);
        checkResult(tag, op, a, b);
        popResult(tag);
    endtask

    initial begin
        logic [W-1:0] ra, rb, held;
        logic [2:0]   ops [6];
        logic [2:0]   rop;
        logic         hv, hc, hz;
        ops = '{ALUOP_AND, ALUOP_OR, ALUOP_ADD, ALUOP_SUB, ALUOP_SLT, 3'b011};

        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.ALUop     = '0;
        bus.A         = '0;
        bus.B         = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset/in_ready",  W'(bus.in_ready),  W'(1));
        checkOutput("reset/out_valid", W'(bus.out_valid), W'(0));
        checkOutput("reset/Result",    bus.Result,        W'(0));
        checkOutput("reset/Overflow",  W'(bus.Overflow),  W'(0));
        checkOutput("reset/CarryOut",  W'(bus.CarryOut),  W'(0));
        checkOutput("reset/Zero",      W'(bus.Zero),      W'(0));
        resetn = 1'b1;

        runOp("add_carry", ALUOP_ADD, W'(32'hFFFF_FFFF), W'(1));
        runOp("sub_borrow", ALUOP_SUB, '0, W'(1));
        runOp("add_ovf", ALUOP_ADD, {1'b0, {(W-1){1'b1}}}, W'(1));
        runOp("slt_ovf", ALUOP_SLT, {1'b1, {(W-1){1'b0}}}, W'(1));
        runOp("and_zero", ALUOP_AND, {(W/8){8'hF0}}, {(W/8){8'h0F}});
        runOp("slt_equal", ALUOP_SLT, W'(5), W'(5));
        runOp("unsupported", 3'b100, '1, '1);

        // Held result must survive backpressure while new requests are ignored.
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus("bp", ALUOP_SUB, ra, rb);
        checkResult("bp", ALUOP_SUB, ra, rb);
        refModel(ALUOP_SUB, ra, rb, held, hv, hc, hz);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.ALUop    = ALUOP_ADD;
            bus.A        = ~ra;
            checkOutput("bp/hold_Result",    bus.Result,        held);
            checkOutput("bp/hold_Overflow",  W'(bus.Overflow),  W'(hv));
            checkOutput("bp/hold_in_ready",  W'(bus.in_ready),  W'(0));
            checkOutput("bp/hold_out_valid", W'(bus.out_valid), W'(1));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        popResult("bp");
        checkOutput("bp/kept_Result", bus.Result, held);
        repeat (6) @(negedge clk);
        checkOutput("bp/no_ghost_op", W'(bus.out_valid), W'(0));

        // Abort an op partway through its limbs.
        @(negedge clk);
        bus.ALUop    = ALUOP_ADD;
        bus.A        = '1;
        bus.B        = '1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        #1;
        checkOutput("abort/out_valid", W'(bus.out_valid), W'(0));
        checkOutput("abort/in_ready",  W'(bus.in_ready),  W'(1));
        checkOutput("abort/Result",    bus.Result,        W'(0));
        @(negedge clk);
        resetn = 1'b1;
        runOp("after_abort", ALUOP_ADD, W'(1), W'(1));

        for (int n = 0; n < 24; n++) begin
            rop = ops[$urandom_range(0, 5)];
            ra  = randWord();
            rb  = ($urandom_range(0, 5) == 0) ? ra : randWord();
            runOp($sformatf("rand%0d", n), rop, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
